nbit_full_subtractor: RTL and testbench
=======================================

// Module: nbit_full_subtractor
// PURPOSE
//  - Registered N-bit ripple-borrow subtractor: D = A - B - BI, with borrow-out BO.
//  - Built from N 1-bit full-subtractor cells chained LSB->MSB on the borrow.
//  - Serves as the exponent/mantissa subtract primitive in the FP datapath.
//  - Result appears one clock after the operands are presented.
// PARAMETERS
//  N  default 8  operand and result width in bits (N >= 1)
// PORTS
//  clk        input   1  single clock; all state updates on rising edge
//  rst_n      input   1  reset, asynchronous assertion, active-low
//  D          output  N  registered difference, A - B - BI (mod 2^N)
//  BO         output  1  registered borrow-out from the MSB cell
//  A          input   N  minuend
//  B          input   N  subtrahend
//  BI         input   1  borrow-in to the LSB cell
//  in_valid   input   1  operands on A/B/BI are valid this cycle
//  out_valid  output  1  D/BO hold a result computed from a valid input
// BEHAVIOUR
//  - Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//  - Port order: clk, rst_n, D, BO, A, B, BI, in_valid, out_valid.
//  - Reset (rst_n=0): D=0, BO=0 and out_valid=0 immediately, without waiting for a clock edge.
//  - Reset is released synchronously to clk. The first edge with rst_n=1 samples normally.
//  - Cell i computes d_i = a_i ^ b_i ^ bin_i.
//  - Cell i borrow-out: bout_i = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i).
//  - bin_0 = BI, bin_i = bout_(i-1), BO = bout_(N-1).
//  - Equivalent: {BO,D} = {1'b0,A} - {1'b0,B} - BI, taken as N+1 bits.
//  - BO=1 iff A < B + BI as unsigned values.
//  - Subtraction path is purely combinational. D/BO register it on each rising clk edge.
//  - Latency is exactly 1 cycle. Throughput is 1 result per cycle, with no stall or backpressure.
//  - D/BO update every cycle, whatever in_valid is.
//  - out_valid is in_valid delayed by one cycle. Consumers must qualify D/BO with out_valid.
//  - Wrap-around: the result is modulo 2^N. Underflow is flagged only via BO, with no saturation.
//  - Drivers wider than N bits are truncated to the low N bits by the connection.
//  - Reset asserted mid-operation: any pending result is discarded and out_valid drops to 0.
//  - Reset asserted mid-operation: the first result after release comes from the operands sampled at that edge.
//  - X/Z on inputs is not handled. Inputs are synchronous to clk and stable around the edge.
// TESTING (N=8; check one cycle after applying inputs with in_valid=1)
//  - Reset: rst_n=0 asynchronously between edges -> D=0, BO=0, out_valid=0 at once.
//  - A=10, B=15, BI=0 -> D=251, BO=1, out_valid=1.
//  - A=10, B=4, BI=1 -> D=5, BO=0. A=50, B=17, BI=1 -> D=32, BO=0.
//  - A=0, B=16, BI=0 -> D=240, BO=1. A=1, B=1, BI=1 -> D=255, BO=1.
//  - A=189, B=20, BI=0 -> D=169, BO=0. A=255, B=0, BI=0 -> D=255, BO=0.
//  - Back-to-back ops on consecutive cycles -> one result per cycle, in order.
//  - Same back-to-back run, in_valid=0 on one cycle -> out_valid=0 on the following cycle.
//  - Random/exhaustive check: {BO,D} == ({1'b0,A} - {1'b0,B} - BI) over all A, B, BI.

Source files
------------

// File: rtl/nbit_full_subtractor.sv
// nbit_full_subtractor
//   Registered N-bit ripple-borrow subtractor: {BO,D} = A - B - BI.
//   N one-bit full-subtractor cells are chained LSB->MSB on the borrow.
//   The difference and borrow-out are registered, so the result appears
//   one clock after the operands. out_valid follows in_valid by one cycle.
//   This block is the exponent/mantissa subtract primitive in the FP datapath.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  async active-low reset (clears D, BO, out_valid)
//   D          out  N  registered difference, mod 2^N
//   BO         out  1  registered borrow-out of the MSB cell
//   A          in   N  minuend
//   B          in   N  subtrahend
//   BI         in   1  borrow-in to the LSB cell
//   in_valid   in   1  A/B/BI carry a real operation this cycle
//   out_valid  out  1  D/BO were computed from a valid operation

// One-bit full-subtractor cell.
module nbit_full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    always_comb begin
        d    = a ^ b ^ bin;
        // Borrow when b exceeds a, or when a == b and a borrow arrives.
        bout = (~a & b) | (~(a ^ b) & bin);
    end
endmodule

module nbit_full_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [N-1:0] D,
    output logic         BO,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         BI,
    input  logic         in_valid,
    output logic         out_valid
);
    localparam int STAGES = 1;

    // bchain[i] is the borrow into cell i; bchain[N] leaves the MSB.
    logic [N:0]        bchain;
    logic [N-1:0]      diff;

    logic [N-1:0]      d_d, d_q;
    logic              bo_d, bo_q;
    logic [STAGES-1:0] vld_pipe_d, vld_pipe_q;

    assign bchain[0] = BI;

    for (genvar i = 0; i < N; i++) begin : g_cell
        nbit_full_subtractor_cell u_cell (
            .a    (A[i]),
            .b    (B[i]),
            .bin  (bchain[i]),
            .d    (diff[i]),
            .bout (bchain[i+1])
        );
    end

    // D/BO register every cycle; out_valid is what qualifies them.
    always_comb begin
        d_d           = diff;
        bo_d          = bchain[N];
        vld_pipe_d    = vld_pipe_q << 1;
        vld_pipe_d[0] = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q        <= '0;
            bo_q       <= 1'b0;
            vld_pipe_q <= '0;
        end else begin
            d_q        <= d_d;
            bo_q       <= bo_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign D         = d_q;
    assign BO        = bo_q;
    assign out_valid = vld_pipe_q[STAGES-1];
endmodule

// File: tb/tb_nbit_full_subtractor.sv
module tb_nbit_full_subtractor;
    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] D;
    logic         BO;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         BI;
    logic         in_valid;
    logic         out_valid;

    int errors = 0;
    int checks = 0;

    nbit_full_subtractor #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D         (D),
        .BO        (BO),
        .A         (A),
        .B         (B),
        .BI        (BI),
        .in_valid  (in_valid),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge register, sample at the next falling edge.
    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi, input logic v);
        A = a; B = b; BI = bi; in_valid = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic vec(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic bi, input logic [N-1:0] ed, input logic ebo);
        drive(a, b, bi, 1'b1);
        chk({tag, ".D"}, 32'(D), 32'(ed));
        chk({tag, ".BO"}, 32'(BO), 32'(ebo));
        chk({tag, ".vld"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        logic [N:0] model;
        logic [N-1:0] ra, rb;
        logic rbi;

        rst_n = 1'b0; A = '0; B = '0; BI = 1'b0; in_valid = 1'b0;
        // Operands present during reset must not leak through.
        @(negedge clk);
        A = 8'd200; B = 8'd3; BI = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst.D", 32'(D), 32'd0);
        chk("rst.BO", 32'(BO), 32'd0);
        chk("rst.vld", 32'(out_valid), 32'd0);
        rst_n = 1'b1;

        // Directed vectors, back-to-back on consecutive cycles.
        vec("v0", 8'd10, 8'd15, 1'b0, 8'd251, 1'b1);
        vec("v1", 8'd10, 8'd4, 1'b1, 8'd5, 1'b0);
        vec("v2", 8'd50, 8'd17, 1'b1, 8'd32, 1'b0);
        vec("v3", 8'd0, 8'd16, 1'b0, 8'd240, 1'b1);
        vec("v4", 8'd1, 8'd1, 1'b1, 8'd255, 1'b1);
        vec("v5", 8'd189, 8'd20, 1'b0, 8'd169, 1'b0);
        vec("v6", 8'd255, 8'd0, 1'b0, 8'd255, 1'b0);
        vec("v7", 8'd0, 8'd255, 1'b1, 8'd0, 1'b1);
        vec("v8", 8'd128, 8'd127, 1'b1, 8'd0, 1'b0);

        // Bubble: in_valid low for one cycle; D/BO still update.
        drive(8'd7, 8'd9, 1'b0, 1'b0);
        chk("gap.vld", 32'(out_valid), 32'd0);
        chk("gap.D", 32'(D), 32'd254);
        chk("gap.BO", 32'(BO), 32'd1);
        vec("v9", 8'd100, 8'd1, 1'b0, 8'd99, 1'b0);

        // Asynchronous reset between edges clears outputs at once.
        A = 8'd3; B = 8'd9; BI = 1'b0; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.D", 32'(D), 32'd0);
        chk("arst.BO", 32'(BO), 32'd0);
        chk("arst.vld", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // First result after release comes from operands at that edge.
        vec("post", 8'd3, 8'd9, 1'b0, 8'd250, 1'b1);

        // Random sweep against the arithmetic model.
        for (int i = 0; i < 3000; i++) begin
            ra = N'($urandom); rb = N'($urandom); rbi = 1'($urandom);
            model = {1'b0, ra} - {1'b0, rb} - {{N{1'b0}}, rbi};
            drive(ra, rb, rbi, 1'b1);
            chk("rnd", {23'd0, BO, D}, {23'd0, model});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
